execute_cycle: RTL

//   EX stage of the 5-stage RV32I pipeline. Consumes the ID/EX register outputs (RegWriteE..RS2_E),

---
 rtl/execute_cycle.sv | 102 ++++++++++
 1 files changed

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// beq/jal resolution and the EX/MEM pipeline register.
module execute_cycle #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ALUSrcE,
    input  logic              MemWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic [2:0]        ALUControlE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              StallM,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [REG_AW-1:0] RD_M,
    output logic [XLEN-1:0]   PCPlus4M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // Operand A forwarding; the unused select code falls back to the RF value
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    // Operand B forwarding; this value is also the store data
    always_comb begin
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    // ALU; unlisted control codes produce zero
    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000: alu_result = src_a + src_b;
            3'b001: alu_result = src_a - src_b;
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b101: alu_result = {{(XLEN-1){1'b0}},
                                  $signed(src_a) < $signed(src_b)};
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == '0);
    assign PCSrcE    = (BranchE & zero) | JumpE;
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM register: reset clears to a bubble, stall holds everything
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RD_M       <= '0;
            PCPlus4M   <= '0;
        end else if (!StallM) begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            RD_M       <= RD_E;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule
